seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, default 100000, meaning clk cycles per digit slot; SHALL be >= 2.
REQ-002 Parameter BLANK_CYC, default 1000, meaning anti-ghost blank cycles at the start of each slot; SHALL be < SCAN_DIV.
REQ-003 Parameter BLINK_FRAMES, default 125, meaning full frames per blink-phase toggle; SHALL be >= 1.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 seg_array  input  28  four digit patterns, active-high segments {g..a} per digit: [27:21] leftmost digit 0, [20:14] digit 1, [13:7] digit 2, [6:0] rightmost digit 3.
REQ-007 dp  input  4  decimal-point request, dp[3] = digit 0 ... dp[0] = digit 3.
REQ-008 sel  input  4  one-hot blink select, same bit order as dp.
REQ-009 blink_en  input  1  enables blinking of digits flagged in sel.
REQ-010 enable  input  1  0 = display dark.
REQ-011 seg  output  8  active-low cathodes: seg[7] = dp, seg[6:0] = g..a.
REQ-012 anode  output  4  active-low digit enables: anode[3] = digit 0 ... anode[0] = digit 3.
REQ-013 frame_done  output  1  one-cycle pulse per completed frame.

Function
REQ-014 Counter scan_cnt SHALL count 0..SCAN_DIV-1 every cycle and wrap to 0.
REQ-015 On scan_cnt wrap, digit index SHALL advance 0->1->2->3->0.
REQ-016 Frame end is the cycle with digit==3 and scan_cnt==SCAN_DIV-1.
REQ-017 At frame end, seg_array and dp SHALL be captured into snapshot registers; the display SHALL use only the snapshot, so mid-frame input changes SHALL NOT be visible until the next frame.
REQ-018 frame_done SHALL be asserted in the cycle after frame end, for exactly one cycle.
REQ-019 Frame counter SHALL count frame ends 0..BLINK_FRAMES-1; on wrap, blink_phase SHALL toggle.
REQ-020 seg and anode SHALL be registered, one cycle latency from the (digit, scan_cnt) state that produced them.
REQ-021 While scan_cnt < BLANK_CYC, anode SHALL be 4'b1111 and seg SHALL be 8'hFF.
REQ-022 Otherwise, anode SHALL be the active-low one-hot of the current digit.
REQ-023 Otherwise, seg SHALL be ~{dp_snap[digit], pattern_snap[digit]}.
REQ-024 Blink blank: if blink_en and sel[digit] and blink_phase==1, seg SHALL be 8'hFF (anode still driven); sel and blink_en are sampled live, not snapshotted.
REQ-025 enable==0 SHALL force anode=4'b1111 and seg=8'hFF; the counters, snapshot and frame_done SHALL keep running.
REQ-026 Multi-hot or zero sel SHALL be legal; each flagged digit blinks independently.
REQ-027 seg_array values outside valid patterns SHALL be displayed bit-for-bit; no decoding is done in this block.

Reset
REQ-028 When reset is high at a clk edge, the block SHALL set: scan_cnt=0, digit=0, frame counter=0, blink_phase=0, snapshots=0, frame_done=0, anode=4'b1111, seg=8'hFF.
REQ-029 Reset mid-frame SHALL abort the frame without a frame_done pulse.
REQ-030 After release, the first frame SHALL display the zero snapshot (all segments off), and the first capture SHALL occur at the first frame end.
REQ-031 reset SHALL take priority over enable and all other inputs.

Verification (SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2)
REQ-032 Reset for 3 cycles, release, seg_array=28'h0 -> anode=1111, seg=FF through reset; after release, anode cycles 0111,1011,1101,1110 with 6 active cycles per slot and 2 dark; frame_done first pulses 32 cycles after release.
REQ-033 seg_array = digits "1234", dp=4'b0100 loaded before first frame end -> second frame seg = ~{0,0000110}, ~{1,1011011}, ~{0,1001111}, ~{0,1100110} on anode 0111/1011/1101/1110 respectively.
REQ-034 seg_array changed during frame 2 at digit 1 -> frame 2 shows the old value on all four digits; new value from frame 3.
REQ-035 blink_en=1, sel=4'b0001 -> digit 3 seg=FF during frames 3-4 and 7-8 (blink_phase=1), normal during frames 1-2 and 5-6; other digits unaffected.
REQ-036 enable=0 for 10 cycles mid-frame -> anode=1111, seg=FF one cycle later; frame_done timing unchanged.
REQ-037 reset pulsed at digit 2, scan_cnt=5 -> no frame_done; snapshot cleared; slot timing restarts at digit 0.

Source files
------------

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Time-multiplexed driver for a 4-digit, common-anode seven-segment display.
// The segment patterns and decimal points are captured once per frame, so
// a frame always shows one consistent value. Each digit slot starts with a
// short dark interval to prevent ghosting. Flagged digits can blink at a
// rate set in whole frames. Outputs are active-low and registered.

module seg_scan_driver #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYC    = 1000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [27:0] seg_array,
    input  logic [3:0]  dp,
    input  logic [3:0]  sel,
    input  logic        blink_en,
    input  logic        enable,
    output logic [7:0]  seg,
    output logic [3:0]  anode,
    output logic        frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM  = CNT_W'(BLANK_CYC);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [FR_W-1:0]  FRAME_LAST = FR_W'(BLINK_FRAMES - 1);
    localparam logic [FR_W-1:0]  FR_ZERO    = FR_W'(0);
    localparam logic [FR_W-1:0]  FR_ONE     = FR_W'(1);

    logic [CNT_W-1:0] scan_cnt_r;
    logic [1:0]       digit_r;
    logic [FR_W-1:0]  frame_cnt_r;
    logic             blink_phase_r;
    logic [27:0]      pattern_snap_r;
    logic [3:0]       dp_snap_r;
    logic             frame_done_r;
    logic [7:0]       seg_r;
    logic [3:0]       anode_r;

    logic             scan_wrap_s;
    logic             frame_end_s;
    logic             in_blank_s;
    logic [6:0]       pat_s;
    logic             dp_bit_s;
    logic [3:0]       anode_on_s;
    logic             blink_sel_s;
    logic [7:0]       seg_nxt_s;
    logic [3:0]       anode_nxt_s;

    assign scan_wrap_s = (scan_cnt_r == SCAN_LAST);
    assign frame_end_s = scan_wrap_s && (digit_r == 2'd3);
    assign in_blank_s  = (scan_cnt_r < BLANK_LIM);

    // Slot timing: scan counter wraps each slot and advances the digit index
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt_r <= CNT_ZERO;
            digit_r    <= 2'd0;
        end else if (scan_wrap_s) begin
            scan_cnt_r <= CNT_ZERO;
            digit_r    <= digit_r + 2'd1;
        end else begin
            scan_cnt_r <= scan_cnt_r + CNT_ONE;
            digit_r    <= digit_r;
        end
    end

    // Capture the display contents at frame end so each frame is consistent
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_snap_r <= 28'd0;
            dp_snap_r      <= 4'd0;
        end else if (frame_end_s) begin
            pattern_snap_r <= seg_array;
            dp_snap_r      <= dp;
        end else begin
            pattern_snap_r <= pattern_snap_r;
            dp_snap_r      <= dp_snap_r;
        end
    end

    // Count frames and toggle the blink phase every BLINK_FRAMES frames
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_r   <= FR_ZERO;
            blink_phase_r <= 1'b0;
        end else if (frame_end_s) begin
            if (frame_cnt_r == FRAME_LAST) begin
                frame_cnt_r   <= FR_ZERO;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                frame_cnt_r   <= frame_cnt_r + FR_ONE;
                blink_phase_r <= blink_phase_r;
            end
        end else begin
            frame_cnt_r   <= frame_cnt_r;
            blink_phase_r <= blink_phase_r;
        end
    end

    // One-cycle frame_done pulse in the cycle after frame end
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= frame_end_s;
        end
    end

    // Select the snapshot pattern, dp bit, anode and blink flag of the current digit
    always_comb begin
        pat_s       = 7'd0;
        dp_bit_s    = 1'b0;
        anode_on_s  = 4'b1111;
        blink_sel_s = 1'b0;
        case (digit_r)
            2'd0: begin
                pat_s       = pattern_snap_r[27:21];
                dp_bit_s    = dp_snap_r[3];
                anode_on_s  = 4'b0111;
                blink_sel_s = sel[3];
            end
            2'd1: begin
                pat_s       = pattern_snap_r[20:14];
                dp_bit_s    = dp_snap_r[2];
                anode_on_s  = 4'b1011;
                blink_sel_s = sel[2];
            end
            2'd2: begin
                pat_s       = pattern_snap_r[13:7];
                dp_bit_s    = dp_snap_r[1];
                anode_on_s  = 4'b1101;
                blink_sel_s = sel[1];
            end
            2'd3: begin
                pat_s       = pattern_snap_r[6:0];
                dp_bit_s    = dp_snap_r[0];
                anode_on_s  = 4'b1110;
                blink_sel_s = sel[0];
            end
            default: begin
                pat_s       = 7'd0;
                dp_bit_s    = 1'b0;
                anode_on_s  = 4'b1111;
                blink_sel_s = 1'b0;
            end
        endcase
    end

    // Next output values: dark when disabled or in the anti-ghost window,
    // blanked segments with anode still driven during the blink-off phase
    always_comb begin
        anode_nxt_s = 4'b1111;
        seg_nxt_s   = 8'hFF;
        if (!enable || in_blank_s) begin
            anode_nxt_s = 4'b1111;
            seg_nxt_s   = 8'hFF;
        end else begin
            anode_nxt_s = anode_on_s;
            if (blink_en && blink_sel_s && blink_phase_r) begin
                seg_nxt_s = 8'hFF;
            end else begin
                seg_nxt_s = ~{dp_bit_s, pat_s};
            end
        end
    end

    // Registered display outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            anode_r <= 4'b1111;
            seg_r   <= 8'hFF;
        end else begin
            anode_r <= anode_nxt_s;
            seg_r   <= seg_nxt_s;
        end
    end

    assign seg        = seg_r;
    assign anode      = anode_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed testbench for seg_scan_driver with small timing parameters.
// Each frame is 4 slots of 8 cycles with 2 dark cycles at the start of a slot.

module tb_seg_scan_driver;

    localparam int SD = 8;
    localparam int BC = 2;

    logic        clk;
    logic        reset;
    logic [27:0] seg_array;
    logic [3:0]  dp;
    logic [3:0]  sel;
    logic        blink_en;
    logic        enable;
    logic [7:0]  seg;
    logic [3:0]  anode;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    logic [3:0] anode_tbl [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    // Digit glyphs, active-high {g..a}
    localparam logic [6:0] G1 = 7'b0000110;
    localparam logic [6:0] G2 = 7'b1011011;
    localparam logic [6:0] G3 = 7'b1001111;
    localparam logic [6:0] G4 = 7'b1100110;
    localparam logic [6:0] G8 = 7'b1111111;

    seg_scan_driver #(
        .SCAN_DIV     (8),
        .BLANK_CYC    (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seg_array  (seg_array),
        .dp         (dp),
        .sel        (sel),
        .blink_en   (blink_en),
        .enable     (enable),
        .seg        (seg),
        .anode      (anode),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s i=%0d: observed %0h expected %0h", tag, idx, obs, exp);
        end
    endtask

    // Step through frame-relative output indices first..last. Output index i
    // reflects slot position i of the frame (digit i/8, scan i%8).
    task automatic run_span(input int first, input int last,
                            input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3,
                            input bit dark, input string tag);
        logic [7:0] segs [4];
        logic [3:0] ea;
        logic [7:0] es;
        int         scan;
        int         dig;
        segs[0] = s0;
        segs[1] = s1;
        segs[2] = s2;
        segs[3] = s3;
        for (int i = first; i <= last; i++) begin
            tick();
            scan = i % SD;
            dig  = i / SD;
            if (dark || scan < BC) begin
                ea = 4'b1111;
                es = 8'hFF;
            end else begin
                ea = anode_tbl[dig];
                es = segs[dig];
            end
            check({tag, "_anode"}, i, {28'd0, anode}, {28'd0, ea});
            check({tag, "_seg"}, i, {24'd0, seg}, {24'd0, es});
            check({tag, "_fdone"}, i, {31'd0, frame_done}, {31'd0, (i == 31)});
        end
    endtask

    initial begin
        reset     = 1'b1;
        seg_array = 28'd0;
        dp        = 4'd0;
        sel       = 4'd0;
        blink_en  = 1'b0;
        enable    = 1'b1;

        // Reset held for 3 cycles: outputs dark, no frame_done
        for (int r = 0; r < 3; r++) begin
            tick();
            check("rst_anode", r, {28'd0, anode}, 32'h0000000F);
            check("rst_seg", r, {24'd0, seg}, 32'h000000FF);
            check("rst_fdone", r, {31'd0, frame_done}, 32'd0);
        end

        // Release; load "1234" with dp on digit 1 and blink digit 3
        reset     = 1'b0;
        seg_array = {G1, G2, G3, G4};
        dp        = 4'b0100;
        blink_en  = 1'b1;
        sel       = 4'b0001;

        // Frame 1: zero snapshot, all segments off
        run_span(0, 31, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, "f1");

        // Frame 2: "1234"; inputs change during digit 1 but stay invisible
        run_span(0, 9, 8'hF9, 8'h24, 8'hB0, 8'h99, 1'b0, "f2a");
        seg_array = {G8, G8, G8, G8};
        dp        = 4'b1111;
        run_span(10, 31, 8'hF9, 8'h24, 8'hB0, 8'h99, 1'b0, "f2b");

        // Frames 3-4: blink phase 1, digit 3 blanked
        run_span(0, 31, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, "f3");
        run_span(0, 31, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, "f4");

        // Frame 5: blink phase 0; enable low for 10 cycles mid-frame
        run_span(0, 12, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "f5a");
        enable = 1'b0;
        run_span(13, 22, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, "f5dark");
        enable = 1'b1;
        run_span(23, 31, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "f5b");

        // Frame 6: phase 0, normal
        run_span(0, 31, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "f6");

        // Frame 7: phase 1 with multi-hot sel (digits 0 and 2)
        sel = 4'b1010;
        run_span(0, 31, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0, "f7");

        // Frame 8: phase 1 but blinking disabled live
        blink_en = 1'b0;
        run_span(0, 31, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "f8");

        // Frame 9: reset at digit 2, scan 5 aborts the frame
        run_span(0, 20, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "f9");
        reset = 1'b1;
        tick();
        check("mid_rst_anode", 0, {28'd0, anode}, 32'h0000000F);
        check("mid_rst_seg", 0, {24'd0, seg}, 32'h000000FF);
        check("mid_rst_fdone", 0, {31'd0, frame_done}, 32'd0);
        reset = 1'b0;

        // Restarted frame: snapshot cleared, slot timing from digit 0
        run_span(0, 31, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, "f10");

        // Next frame: capture happened at the first frame end after reset
        run_span(0, 31, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "f11");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
